// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller feeding the user port of a dual-port BRAM.
// After an arm pulse it waits for an (optional) trigger and a programmable
// delay, then writes cap_len valid samples to consecutive addresses from 0.
//
// Ports:
//   user_clk, user_rst       clock, asynchronous active-high reset
//   din, din_valid           sample stream
//   arm                      one-cycle pulse: start or restart a capture
//   use_trig, trig           trigger enable and level-sampled trigger
//   cap_len, trig_delay      capture length and post-trigger delay, latched on arm
//   bram_addr/din/we         BRAM user port write interface (registered)
//   busy, done               status (registered from state)
//   words_written            words written in the current or last capture
module snapshot_capture_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned DELAY_BITS = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic                  use_trig,
  input  logic                  trig,
  input  logic [ADDR_BITS:0]    cap_len,
  input  logic [DELAY_BITS-1:0] trig_delay,
  output logic [ADDR_BITS-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS:0]    words_written
);

  localparam logic [ADDR_BITS:0]    FullLen = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]    CntOne  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [DELAY_BITS-1:0] DlyOne  = {{(DELAY_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StCapture, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_BITS:0]      len_q;
  logic [ADDR_BITS:0]      count_q;
  logic [DELAY_BITS-1:0]   dly_q;
  logic [DELAY_BITS-1:0]   dcnt_q;
  logic [ADDR_BITS-1:0]    bram_addr_q;
  logic [DATA_WIDTH-1:0]   bram_din_q;
  logic                    bram_we_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    accept;
  logic                    cap_cycle;
  logic                    last_word;
  logic [ADDR_BITS:0]      len_clamped;
  logic [ADDR_BITS:0]      count_inc;

  always_comb begin
    // A zero or oversized length means "fill the whole memory".
    len_clamped = ((cap_len == '0) || (cap_len > FullLen)) ? FullLen : cap_len;
    accept      = ~use_trig | trig;
    // With no delay the trigger-acceptance cycle is already a capture cycle.
    cap_cycle   = (state_q == StCapture) ||
                  ((state_q == StArmed) && accept && (dly_q == '0));
    count_inc   = count_q + CntOne;
    last_word   = (count_inc == len_q);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      dly_q       <= '0;
      dcnt_q      <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bram_we_q <= 1'b0;
      if (arm) begin
        // Arm wins over trigger and data in the same cycle.
        state_q <= StArmed;
        count_q <= '0;
        len_q   <= len_clamped;
        dly_q   <= trig_delay;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        if (cap_cycle && din_valid) begin
          bram_we_q   <= 1'b1;
          bram_addr_q <= count_q[ADDR_BITS-1:0];
          bram_din_q  <= din;
          count_q     <= count_inc;
        end
        if (cap_cycle) begin
          if (din_valid && last_word) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StCapture;
          end
        end else begin
          unique case (state_q)
            StArmed: begin
              if (accept) begin
                state_q <= StDelay;
                dcnt_q  <= dly_q;
              end
            end
            StDelay: begin
              if (dcnt_q == DlyOne) begin
                state_q <= StCapture;
              end else begin
                dcnt_q <= dcnt_q - DlyOne;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bram_addr     = bram_addr_q;
  assign bram_din      = bram_din_q;
  assign bram_we       = bram_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Scoreboard bench: each scenario is a table of per-cycle inputs; a reference
// model derives the expected writes (cycle, addr, data) from the capture rules
// and a monitor pops them whenever bram_we is seen.
module tb_snapshot_capture_ctrl;
  localparam int DW   = 32;
  localparam int AB   = 10;
  localparam int DB   = 16;
  localparam int MAXN = 1200;
  localparam int FULL = 1 << AB;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          arm = 1'b0;
  logic          use_trig = 1'b0;
  logic          trig = 1'b0;
  logic [AB:0]   cap_len = '0;
  logic [DB-1:0] trig_delay = '0;
  logic [AB-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic [AB:0]   words_written;

  snapshot_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .DELAY_BITS(DB)) dut (
    .user_clk      (user_clk),
    .user_rst      (user_rst),
    .din           (din),
    .din_valid     (din_valid),
    .arm           (arm),
    .use_trig      (use_trig),
    .trig          (trig),
    .cap_len       (cap_len),
    .trig_delay    (trig_delay),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 user_clk = ~user_clk;

  int edge_cnt = 0;
  always @(posedge user_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int            ed;
    int            addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic          arm_a  [MAXN];
  logic          trig_a [MAXN];
  logic          val_a  [MAXN];
  logic [DW-1:0] din_a  [MAXN];
  bit            s_ut;
  int            s_len;
  int            s_dly;

  int total = 0;
  int bad = 0;
  int fin_w, fin_len;
  bit fin_any;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < MAXN; i++) begin
      arm_a[i] = 1'b0; trig_a[i] = 1'b0; val_a[i] = 1'b0; din_a[i] = $urandom;
    end
  endtask

  // Expected writes from the rules: each arm opens a segment; the first
  // accepted trigger after the arm cycle starts capture (immediately, or
  // after delay+1 cycles); the first len valid cycles are written one cycle later.
  task automatic model_push(input int n, input int base);
    int len, b, c, s, w;
    bit any;
    len = (s_len == 0 || s_len > FULL) ? FULL : s_len;
    w = 0;
    any = 0;
    for (int a = 0; a < n; a++) begin
      if (arm_a[a]) begin
        b = a + 1;
        while (b < n && !arm_a[b]) b++;
        c = -1;
        for (int k = a + 1; k < b; k++) begin
          if (!s_ut || trig_a[k]) begin c = k; break; end
        end
        w = 0;
        any = 1;
        if (c >= 0) begin
          s = (s_dly == 0) ? c : c + s_dly + 1;
          for (int v = s; v < b && w < len; v++) begin
            if (val_a[v]) begin
              exp_q.push_back('{ed: base + v + 1, addr: w, data: din_a[v]});
              w++;
            end
          end
        end
      end
    end
    fin_w = w; fin_len = len; fin_any = any;
  endtask

  task automatic drive(input int n);
    int base;
    for (int i = 0; i < n; i++) begin
      @(negedge user_clk);
      if (i == 0) begin
        base = edge_cnt;
        use_trig = s_ut;
        cap_len = (AB+1)'(s_len);
        trig_delay = DB'(s_dly);
        model_push(n, base);
      end
      arm = arm_a[i]; trig = trig_a[i]; din_valid = val_a[i]; din = din_a[i];
    end
  endtask

  task automatic tail(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge user_clk);
      arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
    end
  endtask

  task automatic end_checks(input string name);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_done"}, done, (fin_w == fin_len));
    chk({name, "_busy"}, busy, fin_any && (fin_w != fin_len));
    chk({name, "_words"}, words_written, fin_w);
  endtask

  task automatic run(input string name, input int n);
    drive(n);
    tail(3);
    end_checks(name);
  endtask

  // Monitor: every bram_we pulse must match the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge user_clk);
      if (bram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", bram_we, 0);
        end else begin
          e = exp_q.pop_front();
          chk("we_cycle", edge_cnt, e.ed);
          chk("we_addr", bram_addr, e.addr);
          chk("we_data", bram_din, e.data);
        end
      end
      chk("busy_done_excl", busy & done, 0);
    end
  end

  initial begin
    #1;
    chk("rst_addr", bram_addr, 0);
    chk("rst_din", bram_din, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_written, 0);
    @(negedge user_clk);
    user_rst = 1'b0;
    tail(2);

    // Free-run capture, incrementing pattern.
    clear_tab();
    s_ut = 0; s_len = 4; s_dly = 0;
    arm_a[0] = 1'b1;
    for (int i = 1; i < 12; i++) begin
      val_a[i] = 1'b1;
      din_a[i] = 32'h11001101 + 32'(i - 1) * 32'h11111111;
    end
    run("freerun", 12);

    // Triggered with delay 3, trigger at cycle 5.
    clear_tab();
    s_ut = 1; s_len = 2; s_dly = 3;
    arm_a[0] = 1'b1; trig_a[5] = 1'b1;
    for (int i = 0; i < 16; i++) val_a[i] = (i != 0);
    run("trigdly", 16);

    // Gapped valid.
    clear_tab();
    s_ut = 0; s_len = 3; s_dly = 0;
    arm_a[0] = 1'b1;
    val_a[1] = 1'b1; val_a[3] = 1'b1; val_a[5] = 1'b1;
    run("gapped", 8);

    // Full depth via cap_len = 0.
    clear_tab();
    s_ut = 0; s_len = 0; s_dly = 0;
    arm_a[0] = 1'b1;
    for (int i = 1; i < 1040; i++) val_a[i] = 1'b1;
    run("fulldepth", 1040);
    chk("full_last_addr", bram_addr, FULL - 1);

    // Re-arm after two writes with trig high on the re-arm cycle.
    clear_tab();
    s_ut = 1; s_len = 8; s_dly = 0;
    arm_a[0] = 1'b1; arm_a[3] = 1'b1;
    trig_a[1] = 1'b1; trig_a[3] = 1'b1; trig_a[10] = 1'b1;
    for (int i = 1; i < 22; i++) val_a[i] = 1'b1;
    run("rearm", 22);

    // Randomised scenarios.
    for (int r = 0; r < 20; r++) begin
      clear_tab();
      s_ut  = 1'($urandom_range(0, 1));
      s_len = ($urandom_range(0, 9) == 0) ? 1100 : $urandom_range(0, 12);
      s_dly = $urandom_range(0, 4);
      for (int i = 0; i < 60; i++) begin
        arm_a[i]  = (i == 0) || ($urandom_range(0, 29) == 0);
        trig_a[i] = ($urandom_range(0, 5) == 0);
        val_a[i]  = ($urandom_range(0, 3) != 0);
      end
      run("random", 60);
    end

    // Asynchronous reset after 5 of 16 words.
    clear_tab();
    s_ut = 0; s_len = 16; s_dly = 0;
    arm_a[0] = 1'b1;
    for (int i = 1; i < 6; i++) val_a[i] = 1'b1;
    drive(6);
    @(negedge user_clk);
    chk("prerst_words", words_written, 5);
    arm = 1'b0; din_valid = 1'b1;
    #2 user_rst = 1'b1;
    #1;
    chk("arst_addr", bram_addr, 0);
    chk("arst_din", bram_din, 0);
    chk("arst_we", bram_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_words", words_written, 0);
    @(negedge user_clk);
    user_rst = 1'b0;
    repeat (5) @(negedge user_clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_done", done, 0);
    chk("postrst_pending", exp_q.size(), 0);
    din_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snapshot_capture_ctrl.md
Name: snapshot_capture_ctrl

Overview:
- Single-clock capture controller that sits directly upstream of the dual-port Wishbone BRAM's user port.
- Waits for arm, then an optional trigger and a programmable delay, then writes a programmable number of valid samples into consecutive BRAM addresses starting at 0.
- Drives the BRAM user_addr/user_din/user_we and reports status (busy, done, word count) to software registers.

Parameters:
- DATA_WIDTH, 32, width of din and bram_din; matches the BRAM user data width.
- ADDR_BITS, 10, BRAM user address width; capture depth is 2^ADDR_BITS words.
- DELAY_BITS, 16, width of the post-trigger delay count.

Ports:
- user_clk  in  1  sole clock; all state updates on its rising edge.
- user_rst  in  1  reset, asynchronous, active-high.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  din qualifier.
- arm  in  1  one-cycle pulse that starts or restarts a capture.
- use_trig  in  1  1: wait for trig; 0: capture starts immediately after arm.
- trig  in  1  trigger, level-sampled.
- cap_len  in  ADDR_BITS+1  words to capture; latched on arm.
- trig_delay  in  DELAY_BITS  user_clk cycles from trigger to capture start; latched on arm.
- bram_addr  out  ADDR_BITS  to BRAM user_addr.
- bram_din  out  DATA_WIDTH  to BRAM user_din.
- bram_we  out  1  to BRAM user_we.
- busy  out  1  high in ARMED, DELAY or CAPTURE.
- done  out  1  high in DONE.
- words_written  out  ADDR_BITS+1  words written in the current or last capture.

Behaviour:
- Reset (async, user_rst=1): state IDLE; bram_addr=0, bram_din=0, bram_we=0, busy=0, done=0, words_written=0; latched length and delay = 0.
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- Length latching on arm:
  - cap_len=0 or cap_len>2^ADDR_BITS is clamped to 2^ADDR_BITS.
  - trig_delay is latched unchanged.
  - words_written cleared to 0; done cleared.
- arm in any state, including mid-capture: next state ARMED, count=0, re-latch cap_len and trig_delay. arm has priority over trig and din_valid in the same cycle; that cycle's sample is not written.
- ARMED: trigger is accepted when use_trig=0, or use_trig=1 and trig=1.
  - On acceptance with latched delay=0: enter CAPTURE. The acceptance cycle counts as the first capture cycle, so its din is written if din_valid=1.
  - On acceptance with delay D>0: enter DELAY for exactly D cycles; CAPTURE starts on the cycle after the last delay cycle. din during ARMED/DELAY is never written.
- CAPTURE: each cycle with din_valid=1:
  - next cycle: bram_we=1, bram_addr=count[ADDR_BITS-1:0], bram_din=din (registered, 1-cycle latency);
  - count and words_written increment.
  - din_valid=0 produces bram_we=0 next cycle with no address advance.
- When the write of word len-1 is issued, go to DONE. That final bram_we pulse is output in the first DONE cycle.
- Address never wraps: a 2^ADDR_BITS-word capture ends at address 2^ADDR_BITS-1 and words_written=2^ADDR_BITS.
- DONE: bram_we=0 after the final write; done=1, busy=0; words_written holds. Only arm leaves DONE.
- trig is ignored outside ARMED. trig already high when ARMED is entered is accepted on the first ARMED cycle.
- bram_addr/bram_din hold their last values when bram_we=0.
- busy and done are registered from the state; never both high.

Test Plan:
- Reset mid-capture: assert user_rst after 5 of 16 words written -> all outputs 0 immediately (async), state IDLE, no further bram_we.
- Free-run capture: use_trig=0, cap_len=4, trig_delay=0, din=0x11001101 then +0x11111111 each valid cycle, arm pulse -> writes 0x11001101, 0x22112212, 0x33223323, 0x44334434 to addr 0..3 on consecutive cycles; done=1; words_written=4.
- Triggered with delay: use_trig=1, trig_delay=3, cap_len=2, trig pulse at cycle T -> no writes before T+3; samples at T+4 and T+5 written to addr 0 and 1.
- Gapped valid: cap_len=3, din_valid pattern 1,0,1,0,1 -> bram_we pattern 1,0,1,0,1 with addr 0,-,1,-,2; done only after third write.
- Full depth and clamp: cap_len=0 with ADDR_BITS=10 -> 1024 writes, last addr 0x3FF, no wrap to 0, words_written=1024.
- Re-arm mid-capture: arm after 2 of 8 writes, with trig=1 on the same cycle -> no write that cycle, state ARMED, count=0; next accepted trigger restarts at addr 0.
